// File: rtl/gate_scan_pkg.sv
// rtl/gate_scan_pkg.sv - shared state encodings and width helpers for the gate network scanner
// Contents:
//   ST_*            3-bit FSM state encodings (IDLE, APPLY, WAIT, CAPT, DONE)
//   *_DEF           default network shape and settle time
//   tt_width()      truth-table width for a given input/output count
//   idx_width()     vector index width (one extra bit so the terminal compare never wraps)
//   cnt_width()     settle counter width for a given SETTLE
package gate_scan_pkg;

    localparam int N_IN_DEF   = 3;
    localparam int N_OUT_DEF  = 2;
    localparam int SETTLE_DEF = 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_APPLY = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CAPT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic int tt_width(input int n_in, input int n_out);
        return n_out * (2 ** n_in);
    endfunction

    function automatic int idx_width(input int n_in);
        return n_in + 1;
    endfunction

    // The counter only has to reach SETTLE-1; keep at least one bit so
    // the SETTLE==0 and SETTLE==1 builds still declare a legal vector.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

    localparam int TT_W_DEF  = tt_width(N_IN_DEF, N_OUT_DEF);
    localparam int IDX_W_DEF = idx_width(N_IN_DEF);

endpackage

// File: rtl/logic_net3.sv
// rtl/logic_net3.sv - three-input reference gate network used as the scanned device
// Ports:
//   a, b, c   in   network inputs (a is the most significant scan bit)
//   x1        out  c ^ (a & b)
//   x2        out  (a & b) | (c ^ ~b)
module logic_net3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x1,
    output logic x2
);

    logic ab;

    assign ab = a & b;
    assign x1 = c ^ ab;
    assign x2 = ab | (c ^ ~b);

endmodule

// File: rtl/gate_net_scan_ctrl.sv
// rtl/gate_net_scan_ctrl.sv - exhaustive truth-table scanner and checker for a small gate network
// Parameters: N_IN (inputs), N_OUT (outputs), SETTLE (wait cycles before capture, 0 allowed)
// Build option: STOP_ON_FAIL_EN - end the scan at the first mismatching vector
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   scan request, honoured only in IDLE
//   exp_tt    in   expected table, slice i*N_OUT +: N_OUT is vector i
//   in_vec    out  registered drive to the network (MSB = input A)
//   out_vec   in   network outputs, combinational from in_vec
//   busy      out  high in every state but IDLE
//   done      out  one-cycle pulse at end of scan
//   pass      out  all captured slices matched, held until next accepted start
//   fail_idx  out  first mismatching vector index
//   tt        out  captured truth table, held until next accepted start
module gate_net_scan_ctrl
    import gate_scan_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [tt_width(N_IN,N_OUT)-1:0] exp_tt,
    output logic [N_IN-1:0]              in_vec,
    input  logic [N_OUT-1:0]             out_vec,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN-1:0]              fail_idx,
    output logic [tt_width(N_IN,N_OUT)-1:0] tt
);

    localparam int TT_W  = tt_width(N_IN, N_OUT);
    localparam int IDX_W = idx_width(N_IN);
    localparam int CNT_W = cnt_width(SETTLE);
    localparam int N_VEC = 2 ** N_IN;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VEC - 1);
    // Unreachable when SETTLE==0 (WAIT is skipped), so the clamp is harmless.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    int               slice_base;
    logic [N_OUT-1:0] exp_slice;
    logic             mismatch;
    logic             first_fail;

    always_comb begin
        slice_base = int'(idx[N_IN-1:0]) * N_OUT;
        exp_slice  = exp_tt[slice_base +: N_OUT];
        mismatch   = (out_vec != exp_slice);
        // Only the first mismatch of a scan records fail_idx.
        first_fail = mismatch && pass;
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            in_vec   <= '0;
            tt       <= '0;
            pass     <= 1'b0;
            fail_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        tt       <= '0;
                        pass     <= 1'b1;
                        fail_idx <= '0;
                        state    <= ST_APPLY;
                    end
                end

                ST_APPLY: begin
                    in_vec <= idx[N_IN-1:0];
                    cnt    <= '0;
                    state  <= (SETTLE > 0) ? ST_WAIT : ST_CAPT;
                end

                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_CAPT;
                    end
                end

                ST_CAPT: begin
                    tt[slice_base +: N_OUT] <= out_vec;
                    if (first_fail) begin
                        pass     <= 1'b0;
                        fail_idx <= idx[N_IN-1:0];
                    end
`ifdef STOP_ON_FAIL_EN
                    if (first_fail || (idx == IDX_LAST)) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_APPLY;
                    end
`else
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_APPLY;
                    end
`endif
                end

                ST_DONE: begin
                    // in_vec is left on the last vector applied.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
